// File: rtl/dcache_refill_ctrl.sv
// Miss / write-through controller for the MEM-stage 2-way data cache: refills
// load misses with a byte-aligned word, writes byte stores through, counts hits/misses.
module dcache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cache_hit,
    output logic              stall,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    typedef enum logic [2:0] {IDLE, READ, FILL, WRITE, WDONE} state_t;

    state_t state, state_nxt;
    logic   stall_c;
    logic   unused_wdata;

    assign unused_wdata = ^wdata[DATA_W-1:8];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (st_req)                      state_nxt = WRITE;
                else if (ld_req && !cache_hit)   state_nxt = READ;
            end
            READ:    if (mem_ready) state_nxt = FILL;
            FILL:    state_nxt = IDLE;
            WRITE:   if (mem_ready) state_nxt = WDONE;
            WDONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_c    = 1'b0;
        mem_req    = 1'b0;
        fill_valid = 1'b0;
        case (state)
            IDLE:  stall_c = st_req | (ld_req & ~cache_hit);
            READ:  begin stall_c = 1'b1; mem_req = 1'b1; end
            FILL:  begin stall_c = 1'b1; fill_valid = 1'b1; end
            WRITE: begin stall_c = 1'b1; mem_req = 1'b1; end
            default: ;
        endcase
    end

    // Stall must fall during reset even though IDLE derives it from live inputs.
    assign stall = rst_n & stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_addr  <= '0;
            fill_data  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= 4'b0000;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE) begin
                if (st_req) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr;
                    mem_be    <= 4'b0001 << addr[1:0];
                    mem_wdata <= {4{wdata[7:0]}};
                end else if (ld_req) begin
                    if (cache_hit) begin
                        hit_count <= sat_inc(hit_count);
                    end else begin
                        fill_addr  <= addr;
                        mem_we     <= 1'b0;
                        mem_addr   <= {addr[ADDR_W-1:2], 2'b00};
                        mem_be     <= 4'b0000;
                        miss_count <= sat_inc(miss_count);
                    end
                end
            end
            // The addressed byte lands in [7:0] of the refill word.
            if (state == READ && mem_ready)
                fill_data <= mem_rdata >> {fill_addr[1:0], 3'b000};
        end
    end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl: hit, miss refill, byte store,
// store/load priority, mid-read reset and counter saturation (CNT_W=4 copy).
module tb_dcache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_req, st_req, cache_hit, mem_ready;
    logic [31:0] addr, wdata, mem_rdata;

    logic        stall, fill_valid, mem_req, mem_we;
    logic [31:0] fill_addr, fill_data, mem_addr, mem_wdata, hit_count, miss_count;
    logic [3:0]  mem_be;

    logic        stall_4, fill_valid_4, mem_req_4, mem_we_4;
    logic [31:0] fill_addr_4, fill_data_4, mem_addr_4, mem_wdata_4;
    logic [3:0]  mem_be_4, hit_count_4, miss_count_4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dcache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .st_req(st_req), .addr(addr),
        .wdata(wdata), .cache_hit(cache_hit), .stall(stall), .fill_valid(fill_valid),
        .fill_addr(fill_addr), .fill_data(fill_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
    );

    dcache_refill_ctrl #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .st_req(st_req), .addr(addr),
        .wdata(wdata), .cache_hit(cache_hit), .stall(stall_4), .fill_valid(fill_valid_4),
        .fill_addr(fill_addr_4), .fill_data(fill_data_4), .mem_req(mem_req_4), .mem_we(mem_we_4),
        .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4), .mem_be(mem_be_4), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .hit_count(hit_count_4), .miss_count(miss_count_4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        int stall_cnt, req_cnt, fill_cnt, seen;
        logic done;

        rst_n = 1'b0; ld_req = 1'b0; st_req = 1'b0; cache_hit = 1'b0;
        mem_ready = 1'b0; addr = '0; wdata = '0; mem_rdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall",   32'(stall),      32'd0);
        chk("rst_mem_req", 32'(mem_req),    32'd0);
        chk("rst_fill_v",  32'(fill_valid), 32'd0);
        chk("rst_mem_be",  32'(mem_be),     32'd0);
        chk("rst_hits",    hit_count,       32'd0);
        chk("rst_misses",  miss_count,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: hit
        @(negedge clk);
        ld_req = 1'b1; cache_hit = 1'b1; addr = 32'h10;
        #1;
        chk("hit_stall",   32'(stall),   32'd0);
        chk("hit_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        ld_req = 1'b0; cache_hit = 1'b0;
        #1;
        chk("hit_count", hit_count, 32'd1);
        chk("hit_no_req", 32'(mem_req), 32'd0);

        // 2: miss with 3-cycle memory; byte 3 of 0xAABBCCDD lands in [7:0]
        @(negedge clk);
        ld_req = 1'b1; cache_hit = 1'b0; addr = 32'h23;
        stall_cnt = 0; req_cnt = 0; fill_cnt = 0; done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                chk("rd_addr", mem_addr, 32'h20);
                chk("rd_we", 32'(mem_we), 32'd0);
                chk("rd_be", 32'(mem_be), 32'd0);
                mem_ready = (req_cnt == 3);
                mem_rdata = mem_ready ? 32'hAABBCCDD : 32'h0;
            end else begin
                mem_ready = 1'b0;
            end
            if (fill_valid) begin
                fill_cnt++;
                chk("fill_data", fill_data, 32'h000000AA);
                chk("fill_addr", fill_addr, 32'h23);
                cache_hit = 1'b1;
            end
            if (!stall && fill_cnt > 0) done = 1'b1;
            @(negedge clk);
        end
        ld_req = 1'b0; cache_hit = 1'b0; mem_ready = 1'b0;
        #1;
        chk("miss_done",     32'(done), 32'd1);
        chk("miss_stalls",   stall_cnt, 32'd5);
        chk("miss_req_cyc",  req_cnt,   32'd3);
        chk("miss_fills",    fill_cnt,  32'd1);
        chk("miss_count",    miss_count, 32'd1);
        chk("miss_rehit",    hit_count,  32'd2);
        chk("fill_hold",     fill_data,  32'h000000AA);
        chk("fill_v_low",    32'(fill_valid), 32'd0);

        // 3: byte store, memory accepts on the first request cycle
        @(negedge clk);
        st_req = 1'b1; addr = 32'h42; wdata = 32'h12345678;
        #1;
        chk("st_stall0", 32'(stall), 32'd1);
        chk("st_noreq0", 32'(mem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("st_req",   32'(mem_req), 32'd1);
        chk("st_we",    32'(mem_we),  32'd1);
        chk("st_be",    32'(mem_be),  32'h4);
        chk("st_wdata", mem_wdata,    32'h78787878);
        chk("st_addr",  mem_addr,     32'h42);
        chk("st_stall1", 32'(stall),  32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("wdone_stall", 32'(stall),   32'd0);
        chk("wdone_req",   32'(mem_req), 32'd0);
        st_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("st_idle_req",   32'(mem_req), 32'd0);
        chk("st_idle_stall", 32'(stall),   32'd0);

        // 4: store wins over a coincident load miss
        st_req = 1'b1; ld_req = 1'b1; cache_hit = 1'b0; addr = 32'h81; wdata = 32'hA5;
        #1;
        chk("pri_stall", 32'(stall), 32'd1);
        @(negedge clk);
        #1;
        chk("pri_we",    32'(mem_we), 32'd1);
        chk("pri_be",    32'(mem_be), 32'h2);
        chk("pri_addr",  mem_addr,    32'h81);
        chk("pri_wdata", mem_wdata,   32'hA5A5A5A5);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        st_req = 1'b0; ld_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("pri_miss_cnt", miss_count,   32'd1);
        chk("pri_idle_req", 32'(mem_req), 32'd0);

        // 5: asynchronous reset in the middle of a read
        ld_req = 1'b1; cache_hit = 1'b0; addr = 32'h104;
        @(negedge clk);
        #1;
        chk("rr_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_req_drop",   32'(mem_req),    32'd0);
        chk("rr_stall_drop", 32'(stall),      32'd0);
        chk("rr_fill_v",     32'(fill_valid), 32'd0);
        chk("rr_misses",     miss_count,      32'd0);
        @(negedge clk);
        ld_req = 1'b0; rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (fill_valid || mem_req || stall) seen++;
        end
        chk("rr_quiet", seen, 32'd0);

        // 6: 17 hits saturate the 4-bit counter
        ld_req = 1'b1; cache_hit = 1'b1; addr = 32'h200;
        repeat (15) @(posedge clk);
        #1;
        chk("sat_hits4_15", 32'(hit_count_4), 32'hF);
        chk("sat_hits_15",  hit_count,        32'd15);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_hits4_17", 32'(hit_count_4), 32'hF);
        chk("sat_hits_17",  hit_count,        32'd17);
        chk("sat_misses4",  32'(miss_count_4), 32'd0);
        ld_req = 1'b0; cache_hit = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
